// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants: register file geometry and the register address type.
package mips_pkg;
  localparam int REG_ADDR_W = 3;
  localparam int REG_DATA_W = 8;
  localparam int REG_ZERO   = 0;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
endpackage

// File: rtl/reg_file_sb_if.sv
// Decode/writeback bus of the register file; master is the pipeline, slave the register file.
interface reg_file_sb_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
);
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [DATA_W-1:0] rd_data_a;
  logic [DATA_W-1:0] rd_data_b;
  logic              busy_a;
  logic              busy_b;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rsv_en;
  logic [ADDR_W-1:0] rsv_addr;
  logic [ADDR_W:0]   busy_cnt;

  modport master (
    output rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
    input  rd_data_a, rd_data_b, busy_a, busy_b, busy_cnt
  );

  modport slave (
    input  rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
    output rd_data_a, rd_data_b, busy_a, busy_b, busy_cnt
  );
endinterface

// File: rtl/reg_scoreboard.sv
// Per-register busy scoreboard with a registered popcount; register 0 is never busy.
module reg_scoreboard #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_addr,
  output logic [DEPTH-1:0]  busy_vec,
  output logic [ADDR_W:0]   busy_cnt
);
  logic [DEPTH-1:0] busy_nxt;
  logic [ADDR_W:0]  cnt_nxt;

  // Set is applied after clear: a same-cycle reserve is the newer producer.
  always_comb begin
    busy_nxt = busy_vec;
    if (clr_en) busy_nxt[clr_addr] = 1'b0;
    if (set_en) busy_nxt[set_addr] = 1'b1;
    busy_nxt[0] = 1'b0;
    cnt_nxt = '0;
    for (int i = 1; i < DEPTH; i++) cnt_nxt = cnt_nxt + {{ADDR_W{1'b0}}, busy_nxt[i]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_vec <= '0;
      busy_cnt <= '0;
    end else begin
      busy_vec <= busy_nxt;
      busy_cnt <= cnt_nxt;
    end
  end
endmodule

// File: rtl/reg_file_sb.sv
// 2-read/1-write register file with busy scoreboard; r0 reads as zero.
// Optional write-to-read forwarding under `define REGFILE_BYPASS_EN.
module reg_file_sb
  import mips_pkg::*;
#(
  parameter int DATA_W = REG_DATA_W,
  parameter int DEPTH  = 2 ** REG_ADDR_W,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  reg_file_sb_if.slave bus
);
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);
  localparam int                NUM_RD    = 2;

  logic [DEPTH-1:0][DATA_W-1:0]  regs;
  logic [DEPTH-1:0]              busy_vec;
  logic [NUM_RD-1:0][ADDR_W-1:0] rd_addr;
  logic [NUM_RD-1:0][DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]             rd_busy;
  logic                          wr_live;

  assign wr_live = bus.wr_en && (bus.wr_addr != ZERO_ADDR);

  always_ff @(posedge clk) begin
    if (rst) regs <= '0;
    else if (wr_live) regs[bus.wr_addr] <= bus.wr_data;
  end

  reg_scoreboard #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_sb (
    .clk      (clk),
    .rst      (rst),
    .set_en   (bus.rsv_en),
    .set_addr (bus.rsv_addr),
    .clr_en   (bus.wr_en),
    .clr_addr (bus.wr_addr),
    .busy_vec (busy_vec),
    .busy_cnt (bus.busy_cnt)
  );

  assign rd_addr = {bus.rd_addr_b, bus.rd_addr_a};

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic hit;
`ifdef REGFILE_BYPASS_EN
    assign hit = wr_live && (bus.wr_addr == rd_addr[p]);
`else
    assign hit = 1'b0;
`endif
    always_comb begin
      rd_data[p] = regs[rd_addr[p]];
      rd_busy[p] = busy_vec[rd_addr[p]];
      if (rd_addr[p] == ZERO_ADDR) begin
        rd_data[p] = '0;
        rd_busy[p] = 1'b0;
      end else if (hit) begin
        rd_data[p] = bus.wr_data;
        rd_busy[p] = 1'b0;
      end
    end
  end

  assign bus.rd_data_a = rd_data[0];
  assign bus.rd_data_b = rd_data[1];
  assign bus.busy_a    = rd_busy[0];
  assign bus.busy_b    = rd_busy[1];
endmodule

// File: tb/tb_reg_file_sb.sv
// Directed table-driven bench for reg_file_sb; outputs checked mid-cycle before each edge.
module tb_reg_file_sb;
  import mips_pkg::*;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  reg_file_sb_if #(.DATA_W(REG_DATA_W), .ADDR_W(REG_ADDR_W)) bus ();

  reg_file_sb #(.DATA_W(REG_DATA_W), .DEPTH(2 ** REG_ADDR_W), .ADDR_W(REG_ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       wr_en;
    reg_addr_t  wr_addr;
    logic [7:0] wr_data;
    logic       rsv_en;
    reg_addr_t  rsv_addr;
    reg_addr_t  rd_a;
    reg_addr_t  rd_b;
    logic [7:0] ea;
    logic [7:0] eb;
    logic       ba;
    logic       bb;
    logic [3:0] ec;
  } vec_t;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst           = v.rst;
    bus.wr_en     = v.wr_en;
    bus.wr_addr   = v.wr_addr;
    bus.wr_data   = v.wr_data;
    bus.rsv_en    = v.rsv_en;
    bus.rsv_addr  = v.rsv_addr;
    bus.rd_addr_a = v.rd_a;
    bus.rd_addr_b = v.rd_b;
  endtask

  // Drive at negedge, check the pre-edge outputs, the following posedge commits.
  task automatic step(input string name, input vec_t v);
    @(negedge clk);
    drive(v);
    #1;
    check({name, ".rd_data_a"}, bus.rd_data_a, v.ea);
    check({name, ".rd_data_b"}, bus.rd_data_b, v.eb);
    check({name, ".busy_a"}, {7'd0, bus.busy_a}, {7'd0, v.ba});
    check({name, ".busy_b"}, {7'd0, bus.busy_b}, {7'd0, v.bb});
    check({name, ".busy_cnt"}, {4'd0, bus.busy_cnt}, {4'd0, v.ec});
  endtask

  vec_t tbl[12];
  vec_t v;

  initial begin
    n_vec = 0;
    n_err = 0;
    //           rst  we   wa    wd     rsv  ra    rdA   rdB   expA   expB   bA   bB   cnt
    tbl[0]  = '{1'b0,1'b1,3'd3,8'hA5,1'b0,3'd0,3'd1,3'd2,8'h00,8'h00,1'b0,1'b0,4'd0};
    tbl[1]  = '{1'b0,1'b1,3'd0,8'hFF,1'b0,3'd0,3'd3,3'd0,8'hA5,8'h00,1'b0,1'b0,4'd0};
    tbl[2]  = '{1'b0,1'b0,3'd0,8'h00,1'b1,3'd0,3'd0,3'd3,8'h00,8'hA5,1'b0,1'b0,4'd0};
    tbl[3]  = '{1'b0,1'b0,3'd0,8'h00,1'b1,3'd5,3'd0,3'd0,8'h00,8'h00,1'b0,1'b0,4'd0};
    tbl[4]  = '{1'b0,1'b0,3'd0,8'h00,1'b0,3'd0,3'd5,3'd3,8'h00,8'hA5,1'b1,1'b0,4'd1};
    tbl[5]  = '{1'b0,1'b1,3'd5,8'h3C,1'b0,3'd0,3'd3,3'd0,8'hA5,8'h00,1'b0,1'b0,4'd1};
    tbl[6]  = '{1'b0,1'b1,3'd2,8'h11,1'b1,3'd2,3'd5,3'd0,8'h3C,8'h00,1'b0,1'b0,4'd0};
    tbl[7]  = '{1'b0,1'b0,3'd0,8'h00,1'b1,3'd2,3'd2,3'd5,8'h11,8'h3C,1'b1,1'b0,4'd1};
    tbl[8]  = '{1'b0,1'b0,3'd0,8'h00,1'b1,3'd6,3'd2,3'd6,8'h11,8'h00,1'b1,1'b0,4'd1};
    tbl[9]  = '{1'b0,1'b1,3'd7,8'h5A,1'b1,3'd4,3'd6,3'd2,8'h00,8'h11,1'b1,1'b1,4'd2};
    tbl[10] = '{1'b0,1'b1,3'd2,8'h22,1'b0,3'd0,3'd7,3'd4,8'h5A,8'h00,1'b0,1'b1,4'd3};
    tbl[11] = '{1'b0,1'b0,3'd0,8'h00,1'b0,3'd0,3'd2,3'd4,8'h22,8'h00,1'b0,1'b1,4'd2};

    v = '{1'b1,1'b0,3'd0,8'h00,1'b0,3'd0,3'd0,3'd0,8'h00,8'h00,1'b0,1'b0,4'd0};
    drive(v);
    repeat (2) @(posedge clk);

    // Every address reads zero and idle right after reset.
    for (int i = 0; i < 8; i++) begin
      v = '{1'b0,1'b0,3'd0,8'h00,1'b0,3'd0,3'(i),3'(7-i),8'h00,8'h00,1'b0,1'b0,4'd0};
      step($sformatf("rst_rd%0d", i), v);
    end

    for (int i = 0; i < 12; i++) step($sformatf("vec%0d", i), tbl[i]);

    // Same-cycle writeback to a reserved r4 while decode reads it.
`ifdef REGFILE_BYPASS_EN
    v = '{1'b0,1'b1,3'd4,8'h77,1'b0,3'd0,3'd4,3'd6,8'h77,8'h00,1'b0,1'b1,4'd2};
`else
    v = '{1'b0,1'b1,3'd4,8'h77,1'b0,3'd0,3'd4,3'd6,8'h00,8'h00,1'b1,1'b1,4'd2};
`endif
    step("bypass", v);
    v = '{1'b0,1'b0,3'd0,8'h00,1'b0,3'd0,3'd4,3'd2,8'h77,8'h22,1'b0,1'b0,4'd1};
    step("post_wr", v);

    // Fill the scoreboard to its maximum count (r6 already busy, r0 never).
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      v = '{1'b0,1'b0,3'd0,8'h00,1'b1,3'(i),3'd0,3'd0,8'h00,8'h00,1'b0,1'b0,4'd0};
      drive(v);
    end
    v = '{1'b0,1'b0,3'd0,8'h00,1'b0,3'd0,3'd7,3'd1,8'h5A,8'h00,1'b1,1'b1,4'd7};
    step("full", v);

    // Reset overrides a concurrent write and reserve.
    v = '{1'b1,1'b1,3'd1,8'h99,1'b1,3'd3,3'd3,3'd0,8'hA5,8'h00,1'b1,1'b0,4'd7};
    step("rst_mid", v);
    v = '{1'b0,1'b0,3'd0,8'h00,1'b0,3'd0,3'd1,3'd7,8'h00,8'h00,1'b0,1'b0,4'd0};
    step("after_rst0", v);
    v = '{1'b0,1'b0,3'd0,8'h00,1'b0,3'd0,3'd3,3'd4,8'h00,8'h00,1'b0,1'b0,4'd0};
    step("after_rst1", v);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
